// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: TX state encoding, default bit period and idle line level.
package serdes_pkg;

    localparam int   SERDES_DEFAULT_CLKS_PER_BIT = 16;
    localparam logic SERDES_IDLE                 = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_LOAD   = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
        TX_PARITY = 3'd4,
        TX_STOP   = 3'd5
    } serdes_tx_state_t;

endpackage

// File: rtl/serdes_bit_timer.sv
// Loadable down-counter with zero flag; sets the serial bit period for the SERDES TX and RX.
module serdes_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_zero
);
    localparam int             TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;

    // Holds at zero until reloaded, so it never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_zero = (count == '0);

endmodule

// File: rtl/fifo_serializer.sv
// Pops FIFO words and shifts them out as async frames: start, data LSB first, stop.
// Define SERDES_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module fifo_serializer
    import serdes_pkg::*;
#(
    parameter int LOGIC_SIZE   = 8,
    parameter int CLKS_PER_BIT = SERDES_DEFAULT_CLKS_PER_BIT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    output logic                  o_rr,
    input  logic [LOGIC_SIZE-1:0] i_rdata,
    input  logic                  i_rempty,
    output logic                  o_tx,
    output logic                  o_busy
);
    localparam int              IDX_W    = ($clog2(LOGIC_SIZE) > 1) ? $clog2(LOGIC_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LOGIC_SIZE - 1);

    serdes_tx_state_t      state;
    logic [LOGIC_SIZE-1:0] sr;
    logic [IDX_W-1:0]      bit_idx;
    logic                  tx_q;
    logic                  bit_done;
    logic                  timer_load;
    logic                  frame_end;
`ifdef SERDES_PARITY_EN
    logic                  parity_q;
`endif

    assign frame_end  = (state == TX_STOP) && bit_done;
    // NOTE: o_rr is combinational so the pop lands on the same edge that enters LOAD; reset masks it.
    assign o_rr       = !i_rst && i_en && !i_rempty && ((state == TX_IDLE) || frame_end);
    assign o_busy     = (state != TX_IDLE);
    assign o_tx       = tx_q;
    assign timer_load = (state == TX_LOAD) ||
                        (bit_done && (state inside {TX_START, TX_DATA, TX_PARITY}));

    serdes_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_load(timer_load),
        .o_zero(bit_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= TX_IDLE;
            tx_q    <= SERDES_IDLE;
            sr      <= '0;
            bit_idx <= '0;
`ifdef SERDES_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                TX_IDLE: begin
                    if (o_rr) state <= TX_LOAD;
                end
                TX_LOAD: begin
                    sr    <= i_rdata;
                    tx_q  <= 1'b0;
                    state <= TX_START;
`ifdef SERDES_PARITY_EN
                    parity_q <= ^i_rdata;
`endif
                end
                TX_START: begin
                    if (bit_done) begin
                        tx_q    <= sr[0];
                        sr      <= sr >> 1;
                        bit_idx <= '0;
                        state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef SERDES_PARITY_EN
                            tx_q  <= parity_q;
                            state <= TX_PARITY;
`else
                            tx_q  <= SERDES_IDLE;
                            state <= TX_STOP;
`endif
                        end else begin
                            tx_q    <= sr[0];
                            sr      <= sr >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (bit_done) begin
                        tx_q  <= SERDES_IDLE;
                        state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (bit_done) state <= o_rr ? TX_LOAD : TX_IDLE;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer (LOGIC_SIZE=8, CLKS_PER_BIT=4) with a small FIFO model.
// Expected line levels are derived per cycle from the frame format; builds with or without SERDES_PARITY_EN.
module tb_fifo_serializer;
    localparam int LS  = 8;
    localparam int CPB = 4;
`ifdef SERDES_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB    = LS + P + 2;
    localparam int FRAME = NB * CPB + 1;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_en;
    logic       i_rempty;
    logic       o_rr;
    logic       o_tx;
    logic       o_busy;
    logic [7:0] i_rdata;

    logic [7:0] fifo_mem [0:15];
    int         fifo_wr   = 0;
    int         fifo_rd   = 0;
    int         rr_pulses = 0;
    int         checks    = 0;
    int         errors    = 0;

    always #5 clk = ~clk;

    fifo_serializer #(
        .LOGIC_SIZE  (LS),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .o_rr    (o_rr),
        .i_rdata (i_rdata),
        .i_rempty(i_rempty),
        .o_tx    (o_tx),
        .o_busy  (o_busy)
    );

    // FIFO read side: data appears on the edge that samples the read request.
    assign i_rempty = (fifo_wr == fifo_rd);
    always @(posedge clk) begin
        if (o_rr) begin
            i_rdata   <= fifo_mem[fifo_rd[3:0]];
            fifo_rd   <= fifo_rd + 1;
            rr_pulses <= rr_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fifo_mem[fifo_wr[3:0]] = w;
        fifo_wr++;
    endtask

    // Line level k cycles after the o_rr cycle: LOAD keeps idle, then one slot per bit.
    function automatic logic exp_tx(input logic [7:0] w, input int k);
        int s;
        if (k < 2) return 1'b1;
        s = (k - 2) / CPB;
        if (s == 0) return 1'b0;
        if (s <= LS) return w[s-1];
        if (P == 1 && s == LS + 1) return ^w;
        return 1'b1;
    endfunction

    // Called in the o_rr cycle of a frame; walks the frame cycle by cycle.
    task automatic check_frame(input logic [7:0] w, input logic next_rr,
                               input int en_drop_at, input int rst_at);
        int p0;
        p0 = rr_pulses;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check($sformatf("%0h tx k=%0d", w, k), o_tx, exp_tx(w, k));
            check($sformatf("%0h busy k=%0d", w, k), o_busy, 1'b1);
            check($sformatf("%0h rr k=%0d", w, k), o_rr, (k == FRAME) ? next_rr : 1'b0);
            if (k == en_drop_at) i_en = 1'b0;
            if (k == rst_at) begin
                i_rst = 1'b1;
                @(negedge clk);
                check($sformatf("%0h rst tx", w), o_tx, 1'b1);
                check($sformatf("%0h rst busy", w), o_busy, 1'b0);
                check($sformatf("%0h rst rr", w), o_rr, 1'b0);
                check($sformatf("%0h rst pops", w), rr_pulses - p0, 1);
                i_rst = 1'b0;
                return;
            end
        end
        check($sformatf("%0h pops", w), rr_pulses - p0, 1);
        if (!next_rr) begin
            @(negedge clk);
            check($sformatf("%0h idle tx", w), o_tx, 1'b1);
            check($sformatf("%0h idle busy", w), o_busy, 1'b0);
            check($sformatf("%0h idle rr", w), o_rr, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1;
        i_en  = 1'b1;
        push(8'hA5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset tx c=%0d", c), o_tx, 1'b1);
            check($sformatf("reset rr c=%0d", c), o_rr, 1'b0);
            check($sformatf("reset busy c=%0d", c), o_busy, 1'b0);
        end

        i_rst = 1'b0;
        #1 check("a5 rr", o_rr, 1'b1);
        check_frame(8'hA5, 1'b0, 0, 0);

        push(8'h01);
        #1 check("01 rr", o_rr, 1'b1);
        check_frame(8'h01, 1'b0, 0, 0);

        // Back-to-back: the second frame's o_rr falls in the STOP-final cycle.
        push(8'h00);
        push(8'hFF);
        #1 check("00 rr", o_rr, 1'b1);
        check_frame(8'h00, 1'b1, 0, 0);
        check_frame(8'hFF, 1'b0, 0, 0);

        push(8'h3C);
        push(8'h55);
        #1 check("3c rr", o_rr, 1'b1);
        check_frame(8'h3C, 1'b0, 20, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("en-low tx c=%0d", c), o_tx, 1'b1);
            check($sformatf("en-low rr c=%0d", c), o_rr, 1'b0);
        end
        i_en = 1'b1;
        #1 check("en-high rr", o_rr, 1'b1);
        check_frame(8'h55, 1'b0, 0, 0);

        // Reset lands in data bit 3 (cycles 18..21); 0x96 is dropped.
        push(8'h96);
        push(8'h69);
        #1 check("96 rr", o_rr, 1'b1);
        check_frame(8'h96, 1'b0, 0, 19);
        #1 check("post-rst rr", o_rr, 1'b1);
        check_frame(8'h69, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
